// File: rtl/round_controller.sv
// -----------------------------------------------------------------------------
// round_controller
//
// Purpose:
//   Game-round sequencer. Owns the level number and the life count, holds the
//   level timer in reset outside active play, and gates player movement. It
//   turns goal / hit / timeout events into level advance, life loss, win or
//   game over.
//
// Optional feature (compile-time macro EXTRA_LIFE_EN):
//   When defined, a level clear that does not win also grants one life,
//   capped at MAX_LIVES. When undefined, lives only decrement and MAX_LIVES
//   is unused.
//
// Ports:
//   clk          in   1   system clock
//   rst          in   1   synchronous, active-high reset
//   start        in   1   start button (level); its rising edge is used
//   goal_reached in   1   1-cycle pulse: goal reached
//   player_hit   in   1   1-cycle pulse: collision with an enemy
//   time_out     in   1   level timer expired; may stay high for many cycles
//   lvl          out  10  current level, 1..MAX_LVL
//   lives        out  3   remaining lives
//   timer_rst    out  1   1 = hold the level timer at its initial time
//   play_en      out  1   1 = movement and enemies active
//   state        out  3   FSM state code for HUD screen select
//   game_over    out  1   1 while in GAME_OVER
//   win          out  1   1 in GAME_OVER when reached by clearing MAX_LVL
// -----------------------------------------------------------------------------
module round_controller #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BANNER_SEC = 2,
    parameter int INIT_LIVES = 3,
    parameter int MAX_LVL    = 10,
    parameter int MAX_LIVES  = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       goal_reached,
    input  logic       player_hit,
    input  logic       time_out,
    output logic [9:0] lvl,
    output logic [2:0] lives,
    output logic       timer_rst,
    output logic       play_en,
    output logic [2:0] state,
    output logic       game_over,
    output logic       win
);

    localparam int BANNER_CYC = BANNER_SEC * CLK_FREQ;
    // Keep the prescaler at least one bit wide even for a 1-cycle banner.
    localparam int PW = (BANNER_CYC > 1) ? $clog2(BANNER_CYC) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(BANNER_CYC - 1);
    localparam logic [9:0]    LVL_MAX    = 10'(MAX_LVL);
    localparam logic [2:0]    LIVES_INIT = 3'(INIT_LIVES);
`ifdef EXTRA_LIFE_EN
    localparam logic [2:0]    LIVES_CAP  = 3'(MAX_LIVES);
`endif

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_BANNER    = 3'd1,
        S_PLAY      = 3'd2,
        S_LVL_CLEAR = 3'd3,
        S_LIFE_LOST = 3'd4,
        S_GAME_OVER = 3'd5
    } state_t;

    state_t        state_q, state_d;
    logic [9:0]    lvl_q, lvl_d;
    logic [2:0]    lives_q, lives_d;
    logic          win_q, win_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          timer_rst_q, timer_rst_d;
    logic          play_en_q, play_en_d;
    logic          game_over_q, game_over_d;
    logic          start_q, to_q;
    logic          start_re, to_re;

    // Edge registers track their inputs in every state, so a time_out that is
    // already high when PLAY is entered never produces an edge.
    assign start_re = start & ~start_q;
    assign to_re    = time_out & ~to_q;

    always_comb begin
        state_d = state_q;
        lvl_d   = lvl_q;
        lives_d = lives_q;
        win_d   = win_q;
        presc_d = presc_q;

        case (state_q)
            S_IDLE: begin
                if (start_re) begin
                    state_d = S_BANNER;
                    presc_d = '0;
                end
            end
            S_BANNER: begin
                if (presc_q == PRESC_LAST) begin
                    state_d = S_PLAY;
                end else begin
                    presc_d = presc_q + 1'b1;
                end
            end
            S_PLAY: begin
                // Goal beats a simultaneous hit or timeout.
                if (goal_reached) begin
                    state_d = S_LVL_CLEAR;
                end else if (player_hit || to_re) begin
                    state_d = S_LIFE_LOST;
                end
            end
            S_LVL_CLEAR: begin
                if (lvl_q == LVL_MAX) begin
                    win_d   = 1'b1;
                    state_d = S_GAME_OVER;
                end else begin
                    lvl_d   = lvl_q + 10'd1;
`ifdef EXTRA_LIFE_EN
                    lives_d = (lives_q >= LIVES_CAP) ? LIVES_CAP : lives_q + 3'd1;
`endif
                    state_d = S_BANNER;
                    presc_d = '0;
                end
            end
            S_LIFE_LOST: begin
                // <= guards against underflow even if lives were already 0.
                if (lives_q <= 3'd1) begin
                    lives_d = 3'd0;
                    win_d   = 1'b0;
                    state_d = S_GAME_OVER;
                end else begin
                    lives_d = lives_q - 3'd1;
                    state_d = S_BANNER;
                    presc_d = '0;
                end
            end
            S_GAME_OVER: begin
                if (start_re) begin
                    lvl_d   = 10'd1;
                    lives_d = LIVES_INIT;
                    win_d   = 1'b0;
                    state_d = S_BANNER;
                    presc_d = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Decoded from the next state so the registered outputs line up
        // with the registered state code.
        timer_rst_d = (state_d != S_PLAY);
        play_en_d   = (state_d == S_PLAY);
        game_over_d = (state_d == S_GAME_OVER);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            lvl_q       <= 10'd1;
            lives_q     <= LIVES_INIT;
            win_q       <= 1'b0;
            presc_q     <= '0;
            timer_rst_q <= 1'b1;
            play_en_q   <= 1'b0;
            game_over_q <= 1'b0;
            start_q     <= 1'b0;
            to_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            lvl_q       <= lvl_d;
            lives_q     <= lives_d;
            win_q       <= win_d;
            presc_q     <= presc_d;
            timer_rst_q <= timer_rst_d;
            play_en_q   <= play_en_d;
            game_over_q <= game_over_d;
            start_q     <= start;
            to_q        <= time_out;
        end
    end

    assign state     = state_q;
    assign lvl       = lvl_q;
    assign lives     = lives_q;
    assign win       = win_q;
    assign timer_rst = timer_rst_q;
    assign play_en   = play_en_q;
    assign game_over = game_over_q;

endmodule

// File: tb/tb_round_controller.sv
module tb_round_controller;

    localparam int CLK_FREQ   = 10;
    localparam int BANNER_SEC = 1;
    localparam int INIT_LIVES = 3;
    localparam int MAX_LVL    = 2;
    localparam int MAX_LIVES  = 5;
    localparam int BANNER_CYC = CLK_FREQ * BANNER_SEC;

    localparam int M_IDLE = 0, M_BANNER = 1, M_PLAY = 2,
                   M_CLEAR = 3, M_LOST = 4, M_OVER = 5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       goal_reached = 1'b0;
    logic       player_hit = 1'b0;
    logic       time_out = 1'b0;
    logic [9:0] lvl;
    logic [2:0] lives;
    logic       timer_rst;
    logic       play_en;
    logic [2:0] state;
    logic       game_over;
    logic       win;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: game phase, counters as plain integers.
    int m_mode  = M_IDLE;
    int m_lvl   = 1;
    int m_lives = INIT_LIVES;
    int m_win   = 0;
    int m_left  = 0;   // banner cycles remaining
    bit m_start_prev = 1'b0;
    bit m_to_prev    = 1'b0;

    round_controller #(
        .CLK_FREQ  (CLK_FREQ),
        .BANNER_SEC(BANNER_SEC),
        .INIT_LIVES(INIT_LIVES),
        .MAX_LVL   (MAX_LVL),
        .MAX_LIVES (MAX_LIVES)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .goal_reached(goal_reached),
        .player_hit  (player_hit),
        .time_out    (time_out),
        .lvl         (lvl),
        .lives       (lives),
        .timer_rst   (timer_rst),
        .play_en     (play_en),
        .state       (state),
        .game_over   (game_over),
        .win         (win)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_step(input bit r, input bit s, input bit g,
                              input bit h, input bit t);
        bit s_rise, t_rise;
        if (r) begin
            m_mode = M_IDLE; m_lvl = 1; m_lives = INIT_LIVES; m_win = 0;
            m_left = 0; m_start_prev = 1'b0; m_to_prev = 1'b0;
            return;
        end
        s_rise = s && !m_start_prev;
        t_rise = t && !m_to_prev;
        case (m_mode)
            M_IDLE:   if (s_rise) begin m_mode = M_BANNER; m_left = BANNER_CYC; end
            M_BANNER: begin
                m_left--;
                if (m_left == 0) m_mode = M_PLAY;
            end
            M_PLAY: begin
                if (g) m_mode = M_CLEAR;
                else if (h || t_rise) m_mode = M_LOST;
            end
            M_CLEAR: begin
                if (m_lvl == MAX_LVL) begin
                    m_win = 1; m_mode = M_OVER;
                end else begin
                    m_lvl++;
`ifdef EXTRA_LIFE_EN
                    m_lives = (m_lives + 1 > MAX_LIVES) ? MAX_LIVES : m_lives + 1;
`endif
                    m_mode = M_BANNER; m_left = BANNER_CYC;
                end
            end
            M_LOST: begin
                m_lives--;
                if (m_lives <= 0) begin
                    m_lives = 0; m_win = 0; m_mode = M_OVER;
                end else begin
                    m_mode = M_BANNER; m_left = BANNER_CYC;
                end
            end
            default: begin
                if (s_rise) begin
                    m_lvl = 1; m_lives = INIT_LIVES; m_win = 0;
                    m_mode = M_BANNER; m_left = BANNER_CYC;
                end
            end
        endcase
        m_start_prev = s;
        m_to_prev    = t;
    endtask

    // One clock: drive inputs, advance DUT and model, compare on the falling edge.
    task automatic cyc(input bit r, input bit s, input bit g,
                       input bit h, input bit t);
        rst = r; start = s; goal_reached = g; player_hit = h; time_out = t;
        @(posedge clk);
        model_step(r, s, g, h, t);
        @(negedge clk);
        chk("state",     int'(state),     m_mode);
        chk("lvl",       int'(lvl),       m_lvl);
        chk("lives",     int'(lives),     m_lives);
        chk("win",       int'(win),       m_win);
        chk("timer_rst", int'(timer_rst), (m_mode != M_PLAY) ? 1 : 0);
        chk("play_en",   int'(play_en),   (m_mode == M_PLAY) ? 1 : 0);
        chk("game_over", int'(game_over), (m_mode == M_OVER) ? 1 : 0);
    endtask

    task automatic wait_banner();
        repeat (BANNER_CYC) cyc(0, 1, 0, 0, 0);
    endtask

    initial begin
        bit rs, ss, gs, hs, ts;

        // Reset state
        cyc(1, 0, 0, 0, 0);
        chk("rst_state", int'(state), 0);
        chk("rst_lvl", int'(lvl), 1);
        chk("rst_lives", int'(lives), 3);
        chk("rst_timer_rst", int'(timer_rst), 1);

        // Start -> banner -> play after BANNER_CYC cycles
        cyc(0, 1, 0, 0, 0);
        chk("start_banner", int'(state), 1);
        wait_banner();
        chk("banner_play", int'(state), 2);
        chk("banner_play_en", int'(play_en), 1);
        chk("banner_timer_rst", int'(timer_rst), 0);

        // time_out held 50 cycles -> exactly one life lost
        repeat (50) cyc(0, 1, 0, 0, 1);
        chk("to_held_state", int'(state), 2);
        chk("to_held_lives", int'(lives), 2);
        cyc(0, 1, 0, 0, 0);

        // Goal and hit together: level advances, lives unchanged
        cyc(0, 1, 1, 1, 0);
        chk("prio_clear", int'(state), 3);
        cyc(0, 1, 0, 0, 0);
        chk("prio_lvl", int'(lvl), 2);
`ifdef EXTRA_LIFE_EN
        chk("prio_lives", int'(lives), 3);
`else
        chk("prio_lives", int'(lives), 2);
`endif
        wait_banner();

        // Clearing the last level wins
        cyc(0, 1, 1, 0, 0);
        cyc(0, 1, 0, 0, 0);
        chk("win_state", int'(state), 5);
        chk("win_flag", int'(win), 1);
        chk("win_lvl", int'(lvl), 2);
        chk("win_game_over", int'(game_over), 1);

        // Restart from GAME_OVER needs a fresh rising edge of start
        cyc(0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0);
        chk("restart_state", int'(state), 1);
        chk("restart_lvl", int'(lvl), 1);
        chk("restart_lives", int'(lives), 3);
        chk("restart_win", int'(win), 0);
        wait_banner();

        // Three hits -> game over without win
        for (int i = 0; i < 3; i++) begin
            cyc(0, 1, 0, 1, 0);
            cyc(0, 1, 0, 0, 0);
            if (i < 2) wait_banner();
        end
        chk("lose_lives", int'(lives), 0);
        chk("lose_game_over", int'(game_over), 1);
        chk("lose_win", int'(win), 0);

        // Reach level 2, spend lives, then reset mid-play
        cyc(0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0);
        wait_banner();
        cyc(0, 1, 1, 0, 0);
        cyc(0, 1, 0, 0, 0);
        wait_banner();
        for (int i = 0; i < 2; i++) begin
            cyc(0, 1, 0, 1, 0);
            cyc(0, 1, 0, 0, 0);
            wait_banner();
        end
        chk("pre_rst_state", int'(state), 2);
        chk("pre_rst_lvl", int'(lvl), 2);
        cyc(1, 1, 0, 0, 0);
        chk("mid_rst_state", int'(state), 0);
        chk("mid_rst_lvl", int'(lvl), 1);
        chk("mid_rst_lives", int'(lives), 3);
        chk("mid_rst_timer_rst", int'(timer_rst), 1);

        // Randomized play against the model
        ss = 1'b0; ts = 1'b0;
        for (int n = 0; n < 4000; n++) begin
            rs = ($urandom_range(0, 599) == 0);
            if ($urandom_range(0, 7) == 0)  ss = ~ss;
            if ($urandom_range(0, 29) == 0) ts = ~ts;
            gs = ($urandom_range(0, 15) == 0);
            hs = ($urandom_range(0, 19) == 0);
            cyc(rs, ss, gs, hs, ts);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
